// File: rtl/keystore192.sv
// keystore192: AES-192 round-key store.
// Captures the NR+1 round keys streamed by the key expander after its load
// strobe, then replays them forward (encrypt) or reverse (decrypt) under a
// start/next handshake.
// Optional build macro KEYSTORE_PARITY_EN adds per-byte even parity on every
// stored key, checked on read and reported through rk_perr. Without it
// rk_perr is tied low.
module keystore192 #(
    parameter int NR = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [127:0] rk_in,
    output logic         done,
    input  logic         start,
    input  logic         dec,
    input  logic         next,
    output logic [127:0] rk_out,
    output logic         rk_valid,
    output logic         rk_last,
    output logic         rk_perr
);

    localparam int AW = (NR > 0) ? $clog2(NR + 1) : 1;

    localparam logic [AW-1:0] FIRST_ADDR = '0;
    localparam logic [AW-1:0] LAST_ADDR  = AW'(NR);
    localparam logic [AW-1:0] ONE        = AW'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FILL   = 2'd1;
    localparam logic [1:0] S_READY  = 2'd2;
    localparam logic [1:0] S_STREAM = 2'd3;

    logic [1:0]    state_q,    state_d;
    logic [AW-1:0] wcnt_q,     wcnt_d;
    logic [AW-1:0] rptr_q,     rptr_d;
    logic          dir_q,      dir_d;
    logic [127:0]  rk_out_q,   rk_out_d;
    logic          rk_valid_q, rk_valid_d;

    logic [127:0]  mem_q [0:NR];
    logic          mem_we;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

`ifdef KEYSTORE_PARITY_EN
    logic [15:0]   par_q [0:NR];
    logic          rk_perr_q, rk_perr_d;

    // One even-parity bit per byte: set when the byte has an odd number of ones
    function automatic logic [15:0] byte_parity(input logic [127:0] data);
        logic [15:0] p;
        for (int i = 0; i < 16; i++) begin
            p[i] = ^data[8*i +: 8];
        end
        return p;
    endfunction
`endif

    // Sequencing: load always restarts the fill, otherwise fill/ready/stream progress
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        rptr_d     = rptr_q;
        dir_d      = dir_q;
        rk_out_d   = rk_out_q;
        rk_valid_d = rk_valid_q;
        mem_we     = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = rptr_q;

        if (load) begin
            state_d    = S_FILL;
            wcnt_d     = FIRST_ADDR;
            rk_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_FILL: begin
                    mem_we = 1'b1;
                    if (wcnt_q == LAST_ADDR) begin
                        state_d = S_READY;
                    end else begin
                        wcnt_d = wcnt_q + ONE;
                    end
                end
                S_READY: begin
                    if (start) begin
                        rd_addr = dec ? LAST_ADDR : FIRST_ADDR;
                        rptr_d  = rd_addr;
                        dir_d   = dec;
                        rd_en   = 1'b1;
                        state_d = S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (next && rk_valid_q) begin
                        if (rk_last) begin
                            rk_valid_d = 1'b0;
                            state_d    = S_READY;
                        end else begin
                            rd_addr = dir_q ? (rptr_q - ONE) : (rptr_q + ONE);
                            rptr_d  = rd_addr;
                            rd_en   = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (rd_en) begin
            rk_out_d   = mem_q[rd_addr];
            rk_valid_d = 1'b1;
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wcnt_q     <= '0;
            rptr_q     <= '0;
            dir_q      <= 1'b0;
            rk_out_q   <= '0;
            rk_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            rptr_q     <= rptr_d;
            dir_q      <= dir_d;
            rk_out_q   <= rk_out_d;
            rk_valid_q <= rk_valid_d;
        end
    end

    // Key storage: one entry written per fill cycle at the write pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= NR; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[wcnt_q] <= rk_in;
        end
    end

`ifdef KEYSTORE_PARITY_EN
    // Parity flag follows the presented key and clears whenever no key is valid
    always_comb begin
        rk_perr_d = rk_perr_q;
        if (!rk_valid_d) begin
            rk_perr_d = 1'b0;
        end else if (rd_en) begin
            rk_perr_d = |(byte_parity(mem_q[rd_addr]) ^ par_q[rd_addr]);
        end
    end

    // Parity storage written alongside each key, plus the registered error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= NR; i++) begin
                par_q[i] <= '0;
            end
            rk_perr_q <= 1'b0;
        end else begin
            if (mem_we) begin
                par_q[wcnt_q] <= byte_parity(rk_in);
            end
            rk_perr_q <= rk_perr_d;
        end
    end

    assign rk_perr = rk_perr_q;
`else
    assign rk_perr = 1'b0;
`endif

    assign done     = (state_q == S_READY);
    assign rk_out   = rk_out_q;
    assign rk_valid = rk_valid_q;
    assign rk_last  = rk_valid_q && (rptr_q == (dir_q ? FIRST_ADDR : LAST_ADDR));

endmodule

// File: tb/tb_keystore192.sv
// tb_keystore192: self-checking bench for keystore192.
// Keeps a plain array of the keys it fed in and derives every expected
// replay value from the replay order rules.
// Optional build macro KEYSTORE_PARITY_EN enables the parity corruption step.
module tb_keystore192;

   localparam int NR = 12;

   logic         clk = 1'b0;
   logic         reset;
   logic         load;
   logic [127:0] rk_in;
   logic         done;
   logic         start;
   logic         dec;
   logic         next;
   logic [127:0] rk_out;
   logic         rk_valid;
   logic         rk_last;
   logic         rk_perr;

   int checks   = 0;
   int failures = 0;

   logic [127:0] model_mem [0:NR];
   logic [127:0] stim_keys [0:NR];

   keystore192 #(.NR(NR)) dut (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .rk_in    (rk_in),
      .done     (done),
      .start    (start),
      .dec      (dec),
      .next     (next),
      .rk_out   (rk_out),
      .rk_valid (rk_valid),
      .rk_last  (rk_last),
      .rk_perr  (rk_perr)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic l, input logic s, input logic d, input logic n, input logic [127:0] k);
      load  = l;
      start = s;
      dec   = d;
      next  = n;
      rk_in = k;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] randKey();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic randomStimKeys();
      for (int i = 0; i <= NR; i++) begin
         stim_keys[i] = randKey();
      end
   endtask

   // Load cycle followed by NR+1 capture cycles; done must rise exactly after them
   task automatic fillKeys(input bit fromIdle, input bit startAtLoad, input int startDuring);
      applyStimulus(1'b1, startAtLoad, 1'($urandom_range(0, 1)), 1'b0, randKey());
      if (fromIdle) checkOutput("fill_done_c0", done, 1'b0);
      tick();
      for (int k = 0; k <= NR; k++) begin
         applyStimulus(1'b0, (k == startDuring), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), stim_keys[k]);
         checkOutput($sformatf("fill_done_c%0d", k + 1), done, 1'b0);
         checkOutput($sformatf("fill_valid_c%0d", k + 1), rk_valid, 1'b0);
         tick();
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, randKey());
      checkOutput("fill_done_rise", done, 1'b1);
      checkOutput("fill_valid_end", rk_valid, 1'b0);
      for (int i = 0; i <= NR; i++) begin
         model_mem[i] = stim_keys[i];
      end
   endtask

   // mode 0: next held high, 1: next on odd cycles only, 2: random next
   task automatic replay(input logic d, input int mode, input int perrIdx, input int abortAfter);
      int  i;
      int  cyc;
      int  expIdx;
      logic nxt;
      applyStimulus(1'b0, 1'b1, d, 1'b0, randKey());
      checkOutput("rp_start_valid", rk_valid, 1'b0);
      checkOutput("rp_start_done", done, 1'b1);
      tick();
      i   = 0;
      cyc = 0;
      while (i <= NR && cyc < 200) begin
         expIdx = d ? (NR - i) : i;
         if (abortAfter >= 0 && i == abortAfter) begin
            checkOutput("rp_abort_valid", rk_valid, 1'b1);
            return;
         end
         case (mode)
            0:       nxt = 1'b1;
            1:       nxt = 1'(cyc % 2);
            default: nxt = 1'($urandom_range(0, 1));
         endcase
         applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nxt, randKey());
         checkOutput($sformatf("rp_valid_k%0d", expIdx), rk_valid, 1'b1);
         checkOutput($sformatf("rp_key_k%0d", expIdx), rk_out, model_mem[expIdx]);
         checkOutput($sformatf("rp_last_k%0d", expIdx), rk_last, (i == NR));
         checkOutput($sformatf("rp_perr_k%0d", expIdx), rk_perr, (expIdx == perrIdx));
         tick();
         cyc++;
         if (nxt) i++;
      end
      if (cyc >= 200) begin
         checks++;
         failures++;
         $error("[TB] FAIL rp_timeout observed=%0d keys expected=%0d keys", i, NR + 1);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, randKey());
      checkOutput("rp_end_valid", rk_valid, 1'b0);
      checkOutput("rp_end_last", rk_last, 1'b0);
      checkOutput("rp_end_done", done, 1'b1);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_done"}, done, 1'b0);
      checkOutput({tag, "_valid"}, rk_valid, 1'b0);
      checkOutput({tag, "_last"}, rk_last, 1'b0);
      checkOutput({tag, "_perr"}, rk_perr, 1'b0);
      checkOutput({tag, "_out"}, rk_out, 128'h0);
   endtask

   // Directed sequence of steps
   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 128'h0);
      tick();
      tick();
      reset = 1'b0;
      checkAllZero("reset");

      // start and next in IDLE change nothing
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, randKey());
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, randKey());
      checkAllZero("idle_ignore");

      // FIPS-197 AES-192 expanded key
      stim_keys[0]  = 128'h8e73b0f7da0e6452c810f32b809079e5;
      stim_keys[1]  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
      stim_keys[2]  = 128'hec12068e6c827f6b0e7a95b95c56fec2;
      stim_keys[3]  = 128'h4db7b4bd69b5411885a74796e92538fd;
      stim_keys[4]  = 128'he75fad44bb095386485af05721efb14f;
      stim_keys[5]  = 128'ha448f6d94d6dce24aa326360113b30e6;
      stim_keys[6]  = 128'ha25e7ed583b1cf9a27f939436a94f767;
      stim_keys[7]  = 128'hc0a69407d19da4e1ec1786eb6fa64971;
      stim_keys[8]  = 128'h485f703222cb8755e26d135233f0b7b3;
      stim_keys[9]  = 128'h40beeb282f18a2596747d26b458c553e;
      stim_keys[10] = 128'ha7e1466c9411f1df821f750aad07d753;
      stim_keys[11] = 128'hca4005388fcc5006282d166abc3ce7b5;
      stim_keys[12] = 128'he98ba06f448c773c8ecc720401002202;
      fillKeys(1'b1, 1'b0, -1);

      // next while READY is ignored
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, randKey());
         checkOutput("ready_next_valid", rk_valid, 1'b0);
         checkOutput("ready_next_done", done, 1'b1);
         tick();
      end

      // Forward, reverse with stalls, and back-to-back replays
      replay(1'b0, 0, -1, -1);
      checkOutput("fips_last_key", model_mem[NR], 128'he98ba06f448c773c8ecc720401002202);
      replay(1'b1, 1, -1, -1);
      replay(1'b0, 2, -1, -1);

      // Abort mid-stream with a refill of random keys, start ignored during fill
      replay(1'b0, 2, -1, 5);
      randomStimKeys();
      fillKeys(1'b0, 1'b0, 4);
      replay(1'b1, 2, -1, -1);
      replay(1'b0, 0, -1, -1);

      // start and load together: load wins
      randomStimKeys();
      fillKeys(1'b0, 1'b1, -1);
      replay(1'b0, 1, -1, -1);

      // reset in the middle of a fill
      randomStimKeys();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, randKey());
      tick();
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, stim_keys[k]);
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkAllZero("reset_fill");
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1, randKey());
         tick();
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, randKey());
      checkAllZero("reset_idle");
      fillKeys(1'b1, 1'b0, 7);
      replay(1'b1, 0, -1, -1);

`ifdef KEYSTORE_PARITY_EN
      // Corrupt one stored parity bit of entry 5 and replay forward
      dut.par_q[5] = dut.par_q[5] ^ 16'h0001;
      replay(1'b0, 0, 5, -1);
      dut.par_q[5] = dut.par_q[5] ^ 16'h0001;
      replay(1'b0, 2, -1, -1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
